// File: rtl/count_sequencer_pkg.sv
// Shared definitions for the count sequencer and the counter datapath it drives:
// controller state encoding and the default counter width.
package count_sequencer_pkg;

    localparam int CW_DEFAULT = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/count_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active request found
// when scanning upward (with wrap) from the priority pointer.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int PW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);

    logic found_s;
    logic hit_s;
    int   idx_s;

    // Rotating priority scan; the first hit masks all later candidates
    always_comb begin
        gnt     = {NREQ{1'b0}};
        found_s = 1'b0;
        hit_s   = 1'b0;
        idx_s   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx_s      = (int'(ptr) + i) % NREQ;
            hit_s      = req[idx_s] & ~found_s;
            gnt[idx_s] = hit_s;
            found_s    = found_s | hit_s;
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// Arbitrates NREQ requesters onto one shared counter: clear, run until limit,
// abort or request drop, then return the elapsed count with a done pulse.
module count_sequencer
    import count_sequencer_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int CW   = CW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      abort,
    input  logic [NREQ*CW-1:0]   limit,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic [CW-1:0]        result,
    output logic                 busy,
    output logic                 cnt_clr,
    output logic                 cnt_en,
    input  logic [CW-1:0]        cnt_value
);

    localparam int PW = $clog2(NREQ);

    state_t          state_r, state_s;
    logic [NREQ-1:0] grant_r, grant_s;
    logic [NREQ-1:0] done_r, done_s;
    logic [NREQ-1:0] arb_gnt_s;
    logic [CW-1:0]   result_r, result_s;
    logic [CW-1:0]   lim_q_r, lim_q_s;
    logic [CW-1:0]   lim_sel_s;
    logic [PW-1:0]   ptr_r, ptr_s, ptr_after_s;
    logic            busy_r, busy_s;
    logic            clr_r, clr_s;
    logic            en_r, en_s;
    logic            stop_s;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req),
        .ptr (ptr_r),
        .gnt (arb_gnt_s)
    );

    // Limit of the arbitration winner and pointer slot just past the current owner
    always_comb begin
        lim_sel_s   = {CW{1'b0}};
        ptr_after_s = {PW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            lim_sel_s   = lim_sel_s | ({CW{arb_gnt_s[i]}} & limit[i*CW +: CW]);
            ptr_after_s = ptr_after_s | ({PW{grant_r[i]}} & PW'((i + 1) % NREQ));
        end
    end

    // Only the owner's abort/req count; the compare is plain unsigned so full scale is reachable
    assign stop_s = (|(abort & grant_r)) | ~(|(req & grant_r)) | (cnt_value >= lim_q_r);

    // Next-state and next-output logic
    always_comb begin
        state_s  = state_r;
        grant_s  = grant_r;
        done_s   = {NREQ{1'b0}};
        result_s = result_r;
        lim_q_s  = lim_q_r;
        ptr_s    = ptr_r;
        clr_s    = 1'b0;
        en_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (|req) begin
                    grant_s = arb_gnt_s;
                    lim_q_s = lim_sel_s;
                    clr_s   = 1'b1;
                    state_s = S_CLEAR;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CLEAR: begin
                en_s    = 1'b1;
                state_s = S_RUN;
            end
            S_RUN: begin
                if (stop_s) begin
                    result_s = cnt_value;
                    state_s  = S_DONE;
                end else begin
                    en_s = 1'b1;
                end
            end
            S_DONE: begin
                done_s  = grant_r;
                grant_s = {NREQ{1'b0}};
                ptr_s   = ptr_after_s;
                state_s = S_IDLE;
            end
            default: begin
                grant_s = {NREQ{1'b0}};
                state_s = S_IDLE;
            end
        endcase
        busy_s = (state_s != S_IDLE);
    end

    // State and registered outputs; reset pointer gives requester 0 top priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= S_IDLE;
            grant_r  <= {NREQ{1'b0}};
            done_r   <= {NREQ{1'b0}};
            result_r <= {CW{1'b0}};
            lim_q_r  <= {CW{1'b0}};
            ptr_r    <= {PW{1'b0}};
            busy_r   <= 1'b0;
            clr_r    <= 1'b0;
            en_r     <= 1'b0;
        end else begin
            state_r  <= state_s;
            grant_r  <= grant_s;
            done_r   <= done_s;
            result_r <= result_s;
            lim_q_r  <= lim_q_s;
            ptr_r    <= ptr_s;
            busy_r   <= busy_s;
            clr_r    <= clr_s;
            en_r     <= en_s;
        end
    end

    assign grant   = grant_r;
    assign done    = done_r;
    assign result  = result_r;
    assign busy    = busy_r;
    assign cnt_clr = clr_r;
    assign cnt_en  = en_r;

endmodule
